// File: rtl/bram_loader_pkg.sv
// Shared definitions for the HPS download to BRAM loader.
package bram_loader_pkg;

  // Width of the HPS download byte address bus.
  localparam int DL_ADDR_W = 25;

  // Loader FSM encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_CLEAR = 2'd1;
  localparam state_t ST_LOAD  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Default download index per ROM slot.
  localparam logic [7:0] DL_IDX_BIOS = 8'h00;
  localparam logic [7:0] DL_IDX_GAME = 8'h01;
  localparam logic [7:0] DL_IDX_CART = 8'h02;

  // Number of byte-offset bits below the word address (0 for 8-bit, 1 for 16-bit words).
  function automatic int pack_shift(input int data_w);
    return (data_w == 16) ? 1 : 0;
  endfunction

endpackage

// File: rtl/bram_loader_pack.sv
// Byte-to-word packer: pass-through for 8-bit words, little-endian pairing for 16-bit words.
module bram_loader_pack
  import bram_loader_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 clr,
  input  logic                                 flush,
  input  logic                                 byte_vld,
  input  logic [ADDR_W+pack_shift(DATA_W)-1:0] byte_off,
  input  logic [7:0]                           byte_data,
  output logic                                 wr_vld,
  output logic [ADDR_W-1:0]                    wr_addr,
  output logic [DATA_W-1:0]                    wr_data
);

  localparam int SHIFT = pack_shift(DATA_W);
  localparam int OFF_W = ADDR_W + SHIFT;

  logic [7:0]        lo_q, lo_d;
  logic [ADDR_W-1:0] lo_addr_q, lo_addr_d;
  logic              lo_vld_q, lo_vld_d;
  logic [15:0]       word;

  // Word assembly and low-byte latch update.
  always_comb begin
    lo_d      = lo_q;
    lo_addr_d = lo_addr_q;
    lo_vld_d  = lo_vld_q;
    wr_vld    = 1'b0;
    wr_addr   = byte_off[OFF_W-1:SHIFT];
    word      = {byte_data, 8'h00};
    if (clr) begin
      lo_vld_d = 1'b0;
    end else if (DATA_W == 16) begin
      if (flush) begin
        // A lone low byte at session end still lands, high byte zero.
        if (lo_vld_q) begin
          wr_vld   = 1'b1;
          wr_addr  = lo_addr_q;
          word     = {8'h00, lo_q};
          lo_vld_d = 1'b0;
        end
      end else if (byte_vld) begin
        if (!byte_off[0]) begin
          lo_d      = byte_data;
          lo_addr_d = byte_off[OFF_W-1:SHIFT];
          lo_vld_d  = 1'b1;
        end else begin
          // Only pair with the latched byte if it belongs to this word.
          wr_vld   = 1'b1;
          word     = {byte_data,
                      (lo_vld_q && lo_addr_q == byte_off[OFF_W-1:SHIFT]) ? lo_q : 8'h00};
          lo_vld_d = 1'b0;
        end
      end
    end else begin
      wr_vld = byte_vld;
    end
    wr_data = (DATA_W == 8) ? DATA_W'(word[15:8]) : DATA_W'(word);
  end

  // Low-byte latch registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lo_q      <= '0;
      lo_addr_q <= '0;
      lo_vld_q  <= 1'b0;
    end else begin
      lo_q      <= lo_d;
      lo_addr_q <= lo_addr_d;
      lo_vld_q  <= lo_vld_d;
    end
  end

endmodule

// File: rtl/bram_loader.sv
// HPS download loader: optional RAM fill sweep, then byte stream packed into BRAM writes.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a dl_active rising edge with our index
// ST_CLEAR | writing FILL_VALUE to every word, dl_wait high
// ST_LOAD  | accepting download bytes, one write per completed word
// ST_DONE  | single-cycle done pulse, then back to idle
module bram_loader
  import bram_loader_pkg::*;
#(
  parameter int                   DATA_W         = 8,
  parameter int                   ADDR_W         = 10,
  parameter logic [DL_ADDR_W-1:0] BASE_ADDR      = 25'h0,
  parameter logic [7:0]           DL_INDEX       = DL_IDX_BIOS,
  parameter bit                   CLEAR_ON_START = 1'b1,
  parameter logic [DATA_W-1:0]    FILL_VALUE     = '0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 dl_active,
  input  logic [7:0]           dl_index,
  input  logic                 dl_wr,
  input  logic [DL_ADDR_W-1:0] dl_addr,
  input  logic [7:0]           dl_data,
  output logic                 dl_wait,
  output logic                 mem_wren,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_data,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  localparam int                OFF_W     = ADDR_W + pack_shift(DATA_W);
  localparam logic [25:0]       LIMIT     = 26'((2 ** ADDR_W) * (DATA_W / 8));
  localparam logic [ADDR_W-1:0] LAST_WORD = '1;

  if (DATA_W != 8 && DATA_W != 16) begin : g_bad_width
    $error("bram_loader: DATA_W must be 8 or 16");
  end

  state_t                 state_q, state_d;
  logic                   act_q, act_d;
  logic [ADDR_W-1:0]      clr_cnt_q, clr_cnt_d;
  logic                   pend_vld_q, pend_vld_d;
  logic [DL_ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic [7:0]             pend_data_q, pend_data_d;
  logic                   end_req_q, end_req_d;
  logic                   overflow_q, overflow_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   dl_wait_q, dl_wait_d;
  logic                   mem_wren_q, mem_wren_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]      mem_data_q, mem_data_d;

  logic                   sess_start, act_fall, clr_last, ending;
  logic                   byte_vld, pk_clr, pk_flush;
  logic [DL_ADDR_W-1:0]   byte_addr, byte_off;
  logic [7:0]             byte_data;
  logic                   byte_in_range;
  logic                   pk_wr_vld;
  logic [ADDR_W-1:0]      pk_wr_addr;
  logic [DATA_W-1:0]      pk_wr_data;

  assign sess_start = dl_active && !act_q && (dl_index == DL_INDEX);
  assign act_fall   = act_q && !dl_active;
  assign clr_last   = (clr_cnt_q == LAST_WORD);
  assign ending     = end_req_q || act_fall;

  // Pick the byte handed to the packer this cycle; a buffered byte always goes first.
  always_comb begin
    byte_vld  = 1'b0;
    byte_addr = dl_addr;
    byte_data = dl_data;
    pk_flush  = 1'b0;
    pk_clr    = (state_q == ST_IDLE) && sess_start;
    case (state_q)
      ST_CLEAR: begin
        if (clr_last && pend_vld_q) begin
          byte_vld  = 1'b1;
          byte_addr = pend_addr_q;
          byte_data = pend_data_q;
        end
      end
      ST_LOAD: begin
        if (pend_vld_q) begin
          byte_vld  = 1'b1;
          byte_addr = pend_addr_q;
          byte_data = pend_data_q;
        end else if (dl_wr) begin
          byte_vld = 1'b1;
        end
        if (ending && !pend_vld_q && !dl_wr) pk_flush = 1'b1;
      end
      default: ;
    endcase
  end

  // Address window check; the subtraction wraps so below-base addresses are caught separately.
  assign byte_off      = byte_addr - BASE_ADDR;
  assign byte_in_range = (byte_addr >= BASE_ADDR) && ({1'b0, byte_off} < LIMIT);

  bram_loader_pack #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_pack (
    .clock     (clock),
    .reset_n   (reset_n),
    .clr       (pk_clr),
    .flush     (pk_flush),
    .byte_vld  (byte_vld && byte_in_range),
    .byte_off  (byte_off[OFF_W-1:0]),
    .byte_data (byte_data),
    .wr_vld    (pk_wr_vld),
    .wr_addr   (pk_wr_addr),
    .wr_data   (pk_wr_data)
  );

  // FSM next state, fill sweep, pending buffer and write port.
  always_comb begin
    state_d     = state_q;
    act_d       = dl_active;
    clr_cnt_d   = clr_cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    end_req_d   = end_req_q;
    overflow_d  = overflow_q;
    mem_wren_d  = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    case (state_q)
      ST_IDLE: begin
        if (sess_start) begin
          overflow_d = 1'b0;
          pend_vld_d = 1'b0;
          end_req_d  = 1'b0;
          if (CLEAR_ON_START) begin
            // Word 0 goes out together with the state change so the sweep is 2**ADDR_W cycles.
            state_d    = ST_CLEAR;
            clr_cnt_d  = '0;
            mem_wren_d = 1'b1;
            mem_addr_d = '0;
            mem_data_d = FILL_VALUE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_CLEAR: begin
        if (act_fall) end_req_d = 1'b1;
        if (dl_wr) begin
          if (pend_vld_q && !clr_last) begin
            overflow_d = 1'b1;
          end else begin
            pend_vld_d  = 1'b1;
            pend_addr_d = dl_addr;
            pend_data_d = dl_data;
          end
        end else if (clr_last && pend_vld_q) begin
          pend_vld_d = 1'b0;
        end
        if (clr_last) begin
          state_d = ST_LOAD;
        end else begin
          clr_cnt_d  = clr_cnt_q + ADDR_W'(1);
          mem_wren_d = 1'b1;
          mem_addr_d = clr_cnt_q + ADDR_W'(1);
          mem_data_d = FILL_VALUE;
        end
      end
      ST_LOAD: begin
        if (pend_vld_q) begin
          pend_vld_d = dl_wr;
          if (dl_wr) begin
            pend_addr_d = dl_addr;
            pend_data_d = dl_data;
          end
        end
        if (ending) begin
          if (pk_flush) begin
            state_d   = ST_DONE;
            end_req_d = 1'b0;
          end else begin
            end_req_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (byte_vld && !byte_in_range) overflow_d = 1'b1;
    if (pk_wr_vld) begin
      mem_wren_d = 1'b1;
      mem_addr_d = pk_wr_addr;
      mem_data_d = pk_wr_data;
    end
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    dl_wait_d = (state_d == ST_CLEAR);
  end

  // State and output registers; act_q follows dl_active through reset so a held-high
  // download is not mistaken for a new session afterwards.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      act_q       <= dl_active;
      clr_cnt_q   <= '0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      end_req_q   <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dl_wait_q   <= 1'b0;
      mem_wren_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      clr_cnt_q   <= clr_cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      end_req_q   <= end_req_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dl_wait_q   <= dl_wait_d;
      mem_wren_q  <= mem_wren_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
    end
  end

  assign dl_wait  = dl_wait_q;
  assign mem_wren = mem_wren_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bram_loader.sv
// Directed bench: an 8-bit loader (index 01, base 0x100, fill FF) and a 16-bit loader
// (index 02, base 0, no fill) share one download bus.
module tb_bram_loader;

  logic        clock = 1'b0;
  logic        reset_n, dl_active, dl_wr;
  logic [7:0]  dl_index, dl_data;
  logic [24:0] dl_addr;

  logic        u8_wait, u8_wren, u8_busy, u8_done, u8_ovf;
  logic [3:0]  u8_addr;
  logic [7:0]  u8_data;
  logic        u16_wait, u16_wren, u16_busy, u16_done, u16_ovf;
  logic [3:0]  u16_addr;
  logic [15:0] u16_data;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int done8_n = 0;
  int done16_n = 0;

  typedef struct { int c; int a; int d; } wr_t;
  wr_t q8[$];
  wr_t q16[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  bram_loader #(
    .DATA_W(8), .ADDR_W(4), .BASE_ADDR(25'h100), .DL_INDEX(8'h01),
    .CLEAR_ON_START(1'b1), .FILL_VALUE(8'hFF)
  ) u8 (
    .clock(clock), .reset_n(reset_n), .dl_active(dl_active), .dl_index(dl_index),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(u8_wait),
    .mem_wren(u8_wren), .mem_addr(u8_addr), .mem_data(u8_data), .busy(u8_busy),
    .done(u8_done), .overflow(u8_ovf)
  );

  bram_loader #(
    .DATA_W(16), .ADDR_W(4), .BASE_ADDR(25'h0), .DL_INDEX(8'h02),
    .CLEAR_ON_START(1'b0), .FILL_VALUE(16'h0000)
  ) u16 (
    .clock(clock), .reset_n(reset_n), .dl_active(dl_active), .dl_index(dl_index),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(u16_wait),
    .mem_wren(u16_wren), .mem_addr(u16_addr), .mem_data(u16_data), .busy(u16_busy),
    .done(u16_done), .overflow(u16_ovf)
  );

  // Write and done-pulse logger, sampled on the falling edge.
  always @(negedge clock) begin
    if (u8_wren === 1'b1) q8.push_back('{cyc, int'(u8_addr), int'(u8_data)});
    if (u16_wren === 1'b1) q16.push_back('{cyc, int'(u16_addr), int'(u16_data)});
    if (u8_done === 1'b1) done8_n++;
    if (u16_done === 1'b1) done16_n++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [24:0] a, input logic [7:0] d);
    dl_addr = a;
    dl_data = d;
    dl_wr   = 1'b1;
    tick();
    dl_wr   = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; dl_active = 1'b0; dl_wr = 1'b0;
    dl_index = 8'h00; dl_addr = '0; dl_data = '0;
    tick(3);
    total_cnt++;
    if ({u8_wait, u8_wren, u8_busy, u8_done, u8_ovf, u8_addr, u8_data} !== 17'h0)
      $display("FAIL reset_u8: got %h want 0", {u8_wait, u8_wren, u8_busy, u8_done, u8_ovf, u8_addr, u8_data});
    else pass_cnt++;
    total_cnt++;
    if ({u16_wait, u16_wren, u16_busy, u16_done, u16_ovf, u16_addr, u16_data} !== 25'h0)
      $display("FAIL reset_u16: got %h want 0", {u16_wait, u16_wren, u16_busy, u16_done, u16_ovf, u16_addr, u16_data});
    else pass_cnt++;
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_clear();
    int c0;
    q8.delete();
    dl_index = 8'h01; dl_active = 1'b1; c0 = cyc;
    tick();
    for (int i = 0; i <= 16; i++) begin
      total_cnt++;
      if (u8_wait !== (i < 16))
        $display("FAIL clear_wait[%0d]: got %b want %b", i, u8_wait, (i < 16));
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (q8.size() != 16) $display("FAIL clear_count: got %0d want 16", q8.size());
    else pass_cnt++;
    for (int i = 0; i < 16 && i < q8.size(); i++) begin
      total_cnt++;
      if ({q8[i].c, q8[i].a, q8[i].d} !== {c0 + 1 + i, i, 32'hFF})
        $display("FAIL clear_wr[%0d]: got c%0d a%0d d%h want c%0d a%0d d ff",
                 i, q8[i].c, q8[i].a, q8[i].d, c0 + 1 + i, i);
      else pass_cnt++;
    end
  endtask

  task automatic test_load8();
    int c;
    q8.delete();
    c = cyc;
    send(25'h100, 8'hA5);
    send(25'h103, 8'h5A);
    tick(2);
    total_cnt++;
    if (q8.size() != 2) $display("FAIL load8_count: got %0d want 2", q8.size());
    else pass_cnt++;
    if (q8.size() >= 2) begin
      total_cnt++;
      if ({q8[0].c, q8[0].a, q8[0].d} !== {c + 1, 32'd0, 32'hA5})
        $display("FAIL load8_wr0: got c%0d a%0d d%h want c%0d a0 d a5", q8[0].c, q8[0].a, q8[0].d, c + 1);
      else pass_cnt++;
      total_cnt++;
      if ({q8[1].c, q8[1].a, q8[1].d} !== {c + 2, 32'd3, 32'h5A})
        $display("FAIL load8_wr1: got c%0d a%0d d%h want c%0d a3 d 5a", q8[1].c, q8[1].a, q8[1].d, c + 2);
      else pass_cnt++;
    end
    total_cnt++;
    if (u8_ovf !== 1'b0) $display("FAIL load8_ovf: got %b want 0", u8_ovf);
    else pass_cnt++;
  endtask

  task automatic test_end8();
    int d0;
    d0 = done8_n;
    dl_active = 1'b0;
    tick();
    total_cnt++;
    if ({u8_done, u8_busy} !== 2'b11) $display("FAIL end8_done: got done,busy=%b want 11", {u8_done, u8_busy});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({u8_done, u8_busy} !== 2'b00) $display("FAIL end8_idle: got done,busy=%b want 00", {u8_done, u8_busy});
    else pass_cnt++;
    total_cnt++;
    if (done8_n - d0 != 1) $display("FAIL end8_pulses: got %0d want 1", done8_n - d0);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    dl_index = 8'h01; dl_active = 1'b1;
    tick(18);
    q8.delete();
    send(25'h110, 8'h11);
    send(25'h0FF, 8'h22);
    tick(2);
    total_cnt++;
    if (q8.size() != 0) $display("FAIL ovf_nowrite: got %0d writes want 0", q8.size());
    else pass_cnt++;
    total_cnt++;
    if (u8_ovf !== 1'b1) $display("FAIL ovf_set: got %b want 1", u8_ovf);
    else pass_cnt++;
    send(25'h105, 8'h33);
    tick();
    total_cnt++;
    if (q8.size() != 1 || q8[0].a != 5 || q8[0].d != 'h33)
      $display("FAIL ovf_inrange_wr: got %0d writes want 1 at a5 d33", q8.size());
    else pass_cnt++;
    dl_active = 1'b0;
    tick(3);
    total_cnt++;
    if (u8_ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", u8_ovf);
    else pass_cnt++;
  endtask

  task automatic test_pending();
    int c0;
    q8.delete();
    dl_index = 8'h01; dl_active = 1'b1; c0 = cyc;
    tick();
    total_cnt++;
    if ({u8_ovf, u8_wait} !== 2'b01) $display("FAIL pend_start: got ovf,wait=%b want 01", {u8_ovf, u8_wait});
    else pass_cnt++;
    send(25'h102, 8'h77);
    send(25'h104, 8'h88);
    total_cnt++;
    if (u8_ovf !== 1'b1) $display("FAIL pend_drop_ovf: got %b want 1", u8_ovf);
    else pass_cnt++;
    tick(15);
    total_cnt++;
    if (q8.size() != 17) $display("FAIL pend_count: got %0d want 17", q8.size());
    else pass_cnt++;
    if (q8.size() >= 17) begin
      total_cnt++;
      if ({q8[15].c, q8[15].a, q8[15].d} !== {c0 + 16, 32'd15, 32'hFF})
        $display("FAIL pend_lastfill: got c%0d a%0d d%h want c%0d a15 d ff", q8[15].c, q8[15].a, q8[15].d, c0 + 16);
      else pass_cnt++;
      total_cnt++;
      if ({q8[16].c, q8[16].a, q8[16].d} !== {c0 + 17, 32'd2, 32'h77})
        $display("FAIL pend_wr: got c%0d a%0d d%h want c%0d a2 d 77", q8[16].c, q8[16].a, q8[16].d, c0 + 17);
      else pass_cnt++;
    end
    dl_active = 1'b0;
    tick(3);
  endtask

  task automatic test_mid_reset();
    int d0;
    d0 = done8_n;
    dl_index = 8'h01; dl_active = 1'b1;
    tick(5);
    reset_n = 1'b0;
    tick();
    total_cnt++;
    if ({u8_wait, u8_wren, u8_busy, u8_done, u8_ovf, u8_addr, u8_data} !== 17'h0)
      $display("FAIL midrst_outs: got %h want 0", {u8_wait, u8_wren, u8_busy, u8_done, u8_ovf, u8_addr, u8_data});
    else pass_cnt++;
    reset_n = 1'b1;
    q8.delete();
    tick(20);
    total_cnt++;
    if ({u8_busy, q8.size() == 0, done8_n == d0} !== 3'b011)
      $display("FAIL midrst_norestart: got busy=%b writes=%0d done_pulses=%0d want 0 0 0", u8_busy, q8.size(), done8_n - d0);
    else pass_cnt++;
    dl_active = 1'b0;
    tick(2);
  endtask

  task automatic test_index_mismatch();
    int d8, d16;
    q8.delete(); q16.delete();
    d8 = done8_n; d16 = done16_n;
    dl_index = 8'h07; dl_active = 1'b1;
    tick();
    total_cnt++;
    if ({u8_busy, u16_busy} !== 2'b00) $display("FAIL idx_busy: got %b want 00", {u8_busy, u16_busy});
    else pass_cnt++;
    send(25'h100, 8'h44);
    send(25'h000, 8'h55);
    tick(20);
    dl_active = 1'b0;
    tick(3);
    total_cnt++;
    if (q8.size() + q16.size() != 0) $display("FAIL idx_writes: got %0d want 0", q8.size() + q16.size());
    else pass_cnt++;
    total_cnt++;
    if (done8_n - d8 + done16_n - d16 != 0) $display("FAIL idx_done: got %0d pulses want 0", done8_n - d8 + done16_n - d16);
    else pass_cnt++;
  endtask

  task automatic test_pack16();
    int c, c2, e, d0;
    q16.delete();
    d0 = done16_n;
    dl_index = 8'h02; dl_active = 1'b1;
    tick();
    total_cnt++;
    if ({u16_busy, u16_wait} !== 2'b10) $display("FAIL p16_start: got busy,wait=%b want 10", {u16_busy, u16_wait});
    else pass_cnt++;
    c = cyc;
    send(25'h0, 8'h34);
    total_cnt++;
    if (q16.size() != 0) $display("FAIL p16_lowonly: got %0d writes want 0", q16.size());
    else pass_cnt++;
    send(25'h1, 8'h12);
    tick();
    total_cnt++;
    if (q16.size() != 1 || {q16[0].c, q16[0].a, q16[0].d} !== {c + 2, 32'd0, 32'h1234})
      $display("FAIL p16_pair: got %0d writes, first d%h want 1 write c%0d a0 d 1234",
               q16.size(), (q16.size() > 0) ? q16[0].d : -1, c + 2);
    else pass_cnt++;
    c2 = cyc;
    send(25'h5, 8'hAB);
    send(25'h8, 8'hCD);
    tick();
    e = cyc;
    dl_active = 1'b0;
    tick();
    total_cnt++;
    if (u16_done !== 1'b1) $display("FAIL p16_done: got %b want 1", u16_done);
    else pass_cnt++;
    total_cnt++;
    if (q16.size() != 3) $display("FAIL p16_count: got %0d want 3", q16.size());
    else pass_cnt++;
    if (q16.size() >= 3) begin
      total_cnt++;
      if ({q16[1].c, q16[1].a, q16[1].d} !== {c2 + 1, 32'd2, 32'hAB00})
        $display("FAIL p16_orphan: got c%0d a%0d d%h want c%0d a2 d ab00", q16[1].c, q16[1].a, q16[1].d, c2 + 1);
      else pass_cnt++;
      total_cnt++;
      if ({q16[2].c, q16[2].a, q16[2].d} !== {e + 1, 32'd4, 32'h00CD})
        $display("FAIL p16_dangling: got c%0d a%0d d%h want c%0d a4 d 00cd", q16[2].c, q16[2].a, q16[2].d, e + 1);
      else pass_cnt++;
    end
    tick(2);
    total_cnt++;
    if ({u16_busy, done16_n - d0 == 1} !== 2'b01)
      $display("FAIL p16_end: got busy=%b pulses=%0d want 0 1", u16_busy, done16_n - d0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_clear();
    test_load8();
    test_end8();
    test_overflow();
    test_pending();
    test_mid_reset();
    test_index_mismatch();
    test_pack16();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
